// File: rtl/mips_pkg.sv
// Shared MIPS definitions: mul/div op encodings, sequencer FSM states, funct codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  // Multiply/divide operation select driven by the decode controller.
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FIX    = 2'd2,
    DONE_S = 2'd3
  } md_state_t;

  // SPECIAL-opcode funct fields for the HI/LO group, decoded by the controller.
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/md_cneg.sv
// Conditional two's-complement negate: result = neg ? -value : value.
// Latency: combinational.
// Backpressure: none.
// Ports: value (W) operand, neg (1) negate enable, result (W) output.
module md_cneg #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; also serves MTHI/MTLO writes.
// Latency: START edge + WIDTH RUN cycles + FIX cycle, then one-cycle DONE (BUSY = WIDTH+1 cycles).
// Backpressure: STALL holds decode while BUSY and it requests START/MFHI/MFLO/MTHI/MTLO.
// Ports: CLK/RST (async high); START/OP/A/B launch; WHI/WLO/WDATA move-to;
//        RDHI/RDLO move-from requests; HI/LO results; BUSY/DONE/STALL status.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WHI,
  input  logic             WLO,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             RDHI,
  input  logic             RDLO,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             BUSY,
  output logic             DONE,
  output logic             STALL
);

  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);

  md_state_t        state;
  logic [CNTW-1:0]  cnt;
  logic             is_div;
  logic             psign;   // product / quotient sign
  logic             rsign;   // remainder sign (follows the dividend)
  logic             dzero;
  logic [WIDTH-1:0] a_raw;   // kept only for the divide-by-zero HI result
  logic [WIDTH-1:0] opnd;    // multiplicand or divisor
  logic [WIDTH-1:0] acc_hi;  // upper product / partial remainder
  logic [WIDTH-1:0] acc_lo;  // multiplier-then-lower-product / dividend-then-quotient

  // Launch-time operand magnitudes.
  logic             signed_op;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign signed_op = ~OP[0];

  md_cneg #(.W(WIDTH)) u_abs_a (.value(A), .neg(signed_op & A[WIDTH-1]), .result(abs_a));
  md_cneg #(.W(WIDTH)) u_abs_b (.value(B), .neg(signed_op & B[WIDTH-1]), .result(abs_b));

  // Multiply step: add multiplicand into the upper half when the LSB is set,
  // then shift the whole accumulator right, catching the carry at the top.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};

  // Restoring divide step: the partial remainder is always below the divisor,
  // so after the shift a WIDTH+1 bit subtract cannot wrap past bit WIDTH,
  // and trial[WIDTH] is exactly the borrow.
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd};

  // Result fixups, applied at FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  md_cneg #(.W(2*WIDTH)) u_fix_prod (.value({acc_hi, acc_lo}), .neg(psign), .result(prod_fix));
  md_cneg #(.W(WIDTH))   u_fix_quo  (.value(acc_lo), .neg(psign), .result(quo_fix));
  md_cneg #(.W(WIDTH))   u_fix_rem  (.value(acc_hi), .neg(rsign), .result(rem_fix));

  assign BUSY  = (state == RUN) || (state == FIX);
  assign DONE  = (state == DONE_S);
  assign STALL = BUSY & (START | RDHI | RDLO | WHI | WLO);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      psign  <= 1'b0;
      rsign  <= 1'b0;
      dzero  <= 1'b0;
      a_raw  <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            // START takes priority; any same-cycle MTHI/MTLO is dropped.
            is_div <= OP[1];
            psign  <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
            rsign  <= signed_op & A[WIDTH-1];
            dzero  <= (B == '0);
            a_raw  <= A;
            acc_hi <= '0;
            acc_lo <= OP[1] ? abs_a : abs_b;
            opnd   <= OP[1] ? abs_b : abs_a;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            if (WHI) HI <= WDATA;
            if (WLO) LO <= WDATA;
          end
        end
        RUN: begin
          if (is_div) begin
            if (!div_trial[WIDTH]) begin
              acc_hi <= div_trial[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + CNTW'(1);
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            if (dzero) begin
              HI <= a_raw;
              LO <= '1;
            end else begin
              HI <= rem_fix;
              LO <= quo_fix;
            end
          end else begin
            HI <= prod_fix[2*WIDTH-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end
          state <= DONE_S;
        end
        DONE_S: begin
          // Not busy here, so move-to writes are honoured.
          if (WHI) HI <= WDATA;
          if (WLO) LO <= WDATA;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
